// File: rtl/dsp_boot_pkg.sv
// Shared constants for the DSP boot supervisor: state codes and default parameters.
package dsp_boot_pkg;

    localparam int unsigned DEF_BOOT_TIMEOUT      = 65535;
    localparam int unsigned DEF_RETRY_MAX         = 3;
    localparam int unsigned DEF_HOLD_CYCLES       = 16;
    localparam int unsigned DEF_FLAG_SYNC_STAGES  = 2;
    localparam int unsigned DEF_HEARTBEAT_TIMEOUT = 4096;

    localparam int unsigned STATE_W = 3;

    // Codes 6 and 7 are unused; the FSM recovers from them into ST_FAIL.
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE        = 3'd0,
        ST_WAIT_BOOT   = 3'd1,
        ST_DONE        = 3'd2,
        ST_REBOOT      = 3'd3,
        ST_WAIT_ASSERT = 3'd4,
        ST_FAIL        = 3'd5
    } boot_state_e;

endpackage

// File: rtl/dsp_flag_sync.sv
// N-stage synchronizer for one asynchronous DSP boot flag, with an optional
// registered any-edge pulse that lines up with the synchronized output change.
module dsp_flag_sync #(
    parameter int unsigned STAGES  = 2,
    parameter bit          EDGE_EN = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flag_async,
    output logic flag_sync,
    output logic flag_edge
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the raw pin in at the bottom of the chain.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], flag_async};
    end

    // Synchronizer flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign flag_sync = sync_q[STAGES-1];

    if (EDGE_EN) begin : g_edge
        logic edge_q;
        logic edge_d;

        // Last two stages differ exactly when the output is about to toggle.
        always_comb begin
            edge_d = sync_q[STAGES-1] ^ sync_q[STAGES-2];
        end

        // Edge pulse register, high in the same cycle the synced flag changes.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                edge_q <= 1'b0;
            end else begin
                edge_q <= edge_d;
            end
        end

        assign flag_edge = edge_q;
    end else begin : g_no_edge
        assign flag_edge = 1'b0;
    end

endmodule

// File: rtl/dsp_boot_supervisor.sv
// DSP0/DSP1 boot supervisor: waits for DSP reset release, times the boot-done
// flags, requests reboots on timeout up to RETRY_MAX, then latches BOOT_FAIL.
// Optional DONE-state heartbeat monitoring is enabled by `define DSP_BOOT_HEARTBEAT_EN.
// FLAG_SYNC_STAGES must be >= 2 and HOLD_CYCLES >= 1.
module dsp_boot_supervisor
    import dsp_boot_pkg::*;
#(
    parameter int unsigned BOOT_TIMEOUT      = DEF_BOOT_TIMEOUT,
    parameter int unsigned RETRY_MAX         = DEF_RETRY_MAX,
    parameter int unsigned HOLD_CYCLES       = DEF_HOLD_CYCLES,
    parameter int unsigned FLAG_SYNC_STAGES  = DEF_FLAG_SYNC_STAGES,
    parameter int unsigned HEARTBEAT_TIMEOUT = DEF_HEARTBEAT_TIMEOUT
) (
    input  logic                           DSP_CLKIN,
    input  logic                           SYS_RESET_N,
    input  logic                           DSP0_RESET,
    input  logic                           DSP1_RESET,
    input  logic                           DSP0_BOOT_FLAG,
    input  logic                           DSP1_BOOT_FLAG,
    output logic                           REBOOT_REQ,
    output logic                           BOOT_DONE,
    output logic                           BOOT_FAIL,
    output logic [$clog2(RETRY_MAX+1)-1:0] RETRY_COUNT,
    output logic [STATE_W-1:0]             BOOT_STATE
);

    localparam int unsigned CNT_W   = $clog2(BOOT_TIMEOUT + 1);
    localparam int unsigned HOLD_W  = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned RETRY_W = $clog2(RETRY_MAX + 1);

`ifdef DSP_BOOT_HEARTBEAT_EN
    localparam bit HB_EN = 1'b1;
`else
    localparam bit HB_EN = 1'b0;
`endif

    logic               flag0_sync;
    logic               flag1_sync;
    logic               flag0_edge;
    logic               flag1_edge;
    logic               rst_rel_c;
    logic               hb_expired_c;
    logic               timeout_c;

    boot_state_e        state_q;
    boot_state_e        state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [HOLD_W-1:0]  hold_q;
    logic [HOLD_W-1:0]  hold_d;
    logic [RETRY_W-1:0] retry_q;
    logic [RETRY_W-1:0] retry_d;
    logic               boot_done_q;
    logic               boot_done_d;
    logic               reboot_req_q;
    logic               reboot_req_d;
    logic               boot_fail_q;
    logic               boot_fail_d;

    dsp_flag_sync #(
        .STAGES  (FLAG_SYNC_STAGES),
        .EDGE_EN (HB_EN)
    ) u_flag_sync0 (
        .clk        (DSP_CLKIN),
        .rst_n      (SYS_RESET_N),
        .flag_async (DSP0_BOOT_FLAG),
        .flag_sync  (flag0_sync),
        .flag_edge  (flag0_edge)
    );

    dsp_flag_sync #(
        .STAGES  (FLAG_SYNC_STAGES),
        .EDGE_EN (HB_EN)
    ) u_flag_sync1 (
        .clk        (DSP_CLKIN),
        .rst_n      (SYS_RESET_N),
        .flag_async (DSP1_BOOT_FLAG),
        .flag_sync  (flag1_sync),
        .flag_edge  (flag1_edge)
    );

    // DSP resets come from a stage already in this clock domain; used directly.
    assign rst_rel_c = DSP0_RESET & DSP1_RESET;

`ifdef DSP_BOOT_HEARTBEAT_EN
    localparam int unsigned HB_W = $clog2(HEARTBEAT_TIMEOUT + 1);

    logic [HB_W-1:0] hb0_q;
    logic [HB_W-1:0] hb0_d;
    logic [HB_W-1:0] hb1_q;
    logic [HB_W-1:0] hb1_d;

    // Heartbeat counters run only in DONE; held at zero elsewhere so entry starts clean.
    always_comb begin
        hb0_d = '0;
        hb1_d = '0;
        if (state_q == ST_DONE) begin
            if (!flag0_edge) hb0_d = hb0_q + HB_W'(1);
            if (!flag1_edge) hb1_d = hb1_q + HB_W'(1);
        end
    end

    // Heartbeat counter registers; expiry always forces an exit from DONE, so no wrap.
    always_ff @(posedge DSP_CLKIN or negedge SYS_RESET_N) begin
        if (!SYS_RESET_N) begin
            hb0_q <= '0;
            hb1_q <= '0;
        end else begin
            hb0_q <= hb0_d;
            hb1_q <= hb1_d;
        end
    end

    assign hb_expired_c = (hb0_q == HB_W'(HEARTBEAT_TIMEOUT - 1)) |
                          (hb1_q == HB_W'(HEARTBEAT_TIMEOUT - 1));
`else
    localparam int unsigned unused_hb_timeout = HEARTBEAT_TIMEOUT;

    logic unused_edges_c;

    assign unused_edges_c = flag0_edge | flag1_edge;
    assign hb_expired_c   = 1'b0;
`endif

    // Next-state logic; cnt tops out at BOOT_TIMEOUT, which fits CNT_W, so it never wraps.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        retry_d   = retry_q;
        timeout_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (rst_rel_c) begin
                    state_d = ST_WAIT_BOOT;
                end
            end
            ST_WAIT_BOOT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (!rst_rel_c) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (flag0_sync && flag1_sync) begin
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_W'(BOOT_TIMEOUT - 1)) begin
                    timeout_c = 1'b1;
                end
            end
            ST_DONE: begin
                if (!rst_rel_c) begin
                    state_d = ST_IDLE;
                end else if (hb_expired_c) begin
                    timeout_c = 1'b1;
                end
            end
            ST_REBOOT: begin
                if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
                    state_d = ST_WAIT_ASSERT;
                    cnt_d   = '0;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            ST_WAIT_ASSERT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (!rst_rel_c) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(BOOT_TIMEOUT - 1)) begin
                    state_d = ST_FAIL;
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_FAIL;
            end
        endcase

        // Shared timeout action: reboot while retries remain, otherwise give up.
        if (timeout_c) begin
            if (retry_q == RETRY_W'(RETRY_MAX)) begin
                state_d = ST_FAIL;
            end else begin
                retry_d = retry_q + RETRY_W'(1);
                hold_d  = '0;
                state_d = ST_REBOOT;
            end
        end
    end

    // Status outputs follow the next state so they change on the same edge as BOOT_STATE.
    always_comb begin
        boot_done_d  = 1'b0;
        reboot_req_d = 1'b0;
        boot_fail_d  = 1'b0;
        if (state_d == ST_DONE)   boot_done_d  = 1'b1;
        if (state_d == ST_REBOOT) reboot_req_d = 1'b1;
        if (state_d == ST_FAIL)   boot_fail_d  = 1'b1;
    end

    // State, counters and registered outputs.
    always_ff @(posedge DSP_CLKIN or negedge SYS_RESET_N) begin
        if (!SYS_RESET_N) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            hold_q       <= '0;
            retry_q      <= '0;
            boot_done_q  <= 1'b0;
            reboot_req_q <= 1'b0;
            boot_fail_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hold_q       <= hold_d;
            retry_q      <= retry_d;
            boot_done_q  <= boot_done_d;
            reboot_req_q <= reboot_req_d;
            boot_fail_q  <= boot_fail_d;
        end
    end

    assign REBOOT_REQ  = reboot_req_q;
    assign BOOT_DONE   = boot_done_q;
    assign BOOT_FAIL   = boot_fail_q;
    assign RETRY_COUNT = retry_q;
    assign BOOT_STATE  = state_q;

endmodule

// File: doc/dsp_boot_supervisor.md
# dsp_boot_supervisor

Supervises DSP0/DSP1 boot after the reset sequencer releases the DSP reset lines. Runs in the DSP_CLKIN domain directly downstream of the DSP reset stage. Waits for both active-low resets to release, then times the boot-done flags driven by the DSPs on GPIO pins. On timeout it requests a new reset sequence, up to a bounded retry count, then latches a failure.

## Interface
Parameters:
- BOOT_TIMEOUT, 65535: cycles allowed from reset release to both boot flags high; also the limit for upstream re-assertion after REBOOT_REQ.
- RETRY_MAX, 3: reboot attempts before BOOT_FAIL.
- HOLD_CYCLES, 16: REBOOT_REQ high time in cycles; must be ≥ 1.
- FLAG_SYNC_STAGES, 2: synchronizer depth for the boot flags; must be ≥ 2.
- HEARTBEAT_TIMEOUT, 4096: heartbeat limit; used only under DSP_BOOT_HEARTBEAT_EN.

Ports:
- DSP_CLKIN  in  1  sole clock, rising edge.
- SYS_RESET_N  in  1  asynchronous, active-low reset.
- DSP0_RESET  in  1  DSP0 reset from the reset stage, active low, synchronous to DSP_CLKIN.
- DSP1_RESET  in  1  DSP1 reset, same properties as DSP0_RESET.
- DSP0_BOOT_FLAG  in  1  asynchronous DSP0 GPIO; high = boot done.
- DSP1_BOOT_FLAG  in  1  asynchronous DSP1 GPIO; high = boot done.
- REBOOT_REQ  out  1  request to the reset stage to re-run its sequence.
- BOOT_DONE  out  1  both DSPs booted.
- BOOT_FAIL  out  1  retries exhausted; sticky.
- RETRY_COUNT  out  clog2(RETRY_MAX+1)  reboots issued so far.
- BOOT_STATE  out  3  current FSM state code.

## Operation
- All outputs are registered. While SYS_RESET_N is low: every output is 0; state is IDLE; all counters are 0.
- Boot flags pass through FLAG_SYNC_STAGES flops. DSPn_RESET inputs are used unsynchronized.
- FSM states and codes:
  - IDLE (0): when DSP0_RESET and DSP1_RESET are both high → WAIT_BOOT, with cnt cleared to 0.
  - WAIT_BOOT (1): cnt increments every cycle.
    - If both synced flags are high → DONE.
    - Else if cnt reaches BOOT_TIMEOUT-1 → timeout action.
    - If both conditions hold on the same cycle, DONE wins.
    - If either DSPn_RESET goes low → IDLE; cnt is cleared and RETRY_COUNT is unchanged.
  - Timeout action: if RETRY_COUNT == RETRY_MAX → FAIL. Otherwise RETRY_COUNT increments and the FSM → REBOOT.
  - DONE (2): BOOT_DONE = 1. If either DSPn_RESET goes low → IDLE and BOOT_DONE clears.
  - REBOOT (3): REBOOT_REQ = 1 for exactly HOLD_CYCLES cycles, then → WAIT_ASSERT with cnt cleared.
  - WAIT_ASSERT (4): on the first cycle either DSPn_RESET is low → IDLE. If cnt reaches BOOT_TIMEOUT-1 first → FAIL.
  - FAIL (5): BOOT_FAIL = 1. Exit only via SYS_RESET_N.
- cnt is shared by WAIT_BOOT and WAIT_ASSERT. Width is clog2(BOOT_TIMEOUT+1). It never wraps.
- RETRY_COUNT saturates at RETRY_MAX. It is cleared only by SYS_RESET_N.
- Codes 6 and 7 are unreachable. If reached, the FSM goes to FAIL on the next edge.

## Timing
- Flag path: a pin change before edge e is visible in the FSM at edge e+FLAG_SYNC_STAGES-1. State and BOOT_DONE update at edge e+FLAG_SYNC_STAGES. Total latency is FLAG_SYNC_STAGES+1 edges.
- Reset release: both DSPn_RESET high at edge k → BOOT_STATE=1 after edge k+1.
- Timeout: the first cycle in WAIT_BOOT has cnt=0. The transition out occurs at the edge where cnt == BOOT_TIMEOUT-1, i.e. BOOT_TIMEOUT cycles after entry.
- REBOOT_REQ rises on the edge entering REBOOT and falls HOLD_CYCLES edges later.
- SYS_RESET_N asserted mid-operation clears all state asynchronously. This includes an active REBOOT_REQ.

## Configuration
- DSP_BOOT_HEARTBEAT_EN defined:
  - In DONE, each DSP has a heartbeat counter. It clears on any edge of that DSP's synced flag and otherwise increments.
  - If either counter reaches HEARTBEAT_TIMEOUT-1, the FSM takes the timeout action (REBOOT or FAIL).
  - Counters clear on entry to DONE.
- DSP_BOOT_HEARTBEAT_EN undefined:
  - DONE holds regardless of flag activity; a flag falling in DONE is ignored.
  - No heartbeat logic is generated, and HEARTBEAT_TIMEOUT is unused.

## Structure
- Package dsp_boot_pkg holds:
  - the state encoding constants (IDLE=0 … FAIL=5);
  - the default parameter constants.
- Sub-module dsp_flag_sync: an N-stage synchronizer with a registered any-edge pulse output. It is instantiated once per DSP flag; the edge output feeds the heartbeat logic.

## Test plan
Bench parameters: BOOT_TIMEOUT=100, RETRY_MAX=2, HOLD_CYCLES=16, FLAG_SYNC_STAGES=2.
- Resets release; both flags rise 40 cycles later → BOOT_DONE=1 3 edges after the flag edge; RETRY_COUNT=0; REBOOT_REQ never asserts.
- Flags never rise → REBOOT_REQ high for exactly 16 cycles starting 100 cycles after release. Bench drops the resets, then re-releases them → RETRY_COUNT=1.
- Flags never rise across three release cycles → BOOT_FAIL=1 and RETRY_COUNT=2. BOOT_FAIL stays high until SYS_RESET_N pulses low.
- Both flags rise on the exact cycle cnt hits 99 → DONE is taken; no REBOOT_REQ.
- After REBOOT_REQ the resets never go low → BOOT_FAIL=1 100 cycles after REBOOT_REQ falls.
- SYS_RESET_N low during REBOOT → REBOOT_REQ=0 immediately (asynchronous); BOOT_STATE=0. With DSP_BOOT_HEARTBEAT_EN and HEARTBEAT_TIMEOUT=50, a flag held static for 50 cycles in DONE → REBOOT_REQ asserts.
